// File: rtl/exec_alu_stage_pkg.sv
// Shared definitions for the execute ALU stage: op codes, FSM encoding, width default.
package exec_alu_stage_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Op codes shared with the R-type decoder.
    localparam logic [3:0] OP_ILLEGAL = 4'b0000;
    localparam logic [3:0] OP_ADD     = 4'b0001;
    localparam logic [3:0] OP_SUB     = 4'b0010;
    localparam logic [3:0] OP_SLL     = 4'b0011;
    localparam logic [3:0] OP_SLT     = 4'b0100;
    localparam logic [3:0] OP_SLTU    = 4'b0101;
    localparam logic [3:0] OP_XOR     = 4'b0110;
    localparam logic [3:0] OP_SRL     = 4'b0111;
    localparam logic [3:0] OP_SRA     = 4'b1000;
    localparam logic [3:0] OP_OR      = 4'b1001;
    localparam logic [3:0] OP_AND     = 4'b1010;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // True for the three shift op codes.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/exec_alu_stage_iter_shifter.sv
// Iterative 1-bit-per-cycle shifter: work register, down counter and done indication.
module exec_alu_stage_iter_shifter
    import exec_alu_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_value,
    input  logic [SHW-1:0]  i_amount,
    input  logic [4:0]      i_rd,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_value,
    output logic [4:0]      o_rd
);

    localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    state_e          r_state;
    state_e          w_state_nxt;
    logic [XLEN-1:0] r_work;
    logic [SHW-1:0]  r_cnt;
    logic [3:0]      r_op;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] w_shifted;
    logic            w_done;

    // One-bit shift of the work register according to the held op.
    always_comb begin
        w_shifted = r_work;
        case (r_op)
            OP_SLL:  w_shifted = {r_work[XLEN-2:0], 1'b0};
            OP_SRL:  w_shifted = {1'b0, r_work[XLEN-1:1]};
            OP_SRA:  w_shifted = {r_work[XLEN-1], r_work[XLEN-1:1]};
            default: w_shifted = r_work;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; done fires in the cycle the counter steps from 1 to 0.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_ONE) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Work register, counter and holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= {XLEN{1'b0}};
            r_cnt  <= {SHW{1'b0}};
            r_op   <= OP_ILLEGAL;
            r_rd   <= 5'd0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_work <= i_value;
            r_cnt  <= i_amount;
            r_op   <= i_op;
            r_rd   <= i_rd;
        end else if (r_state == ST_SHIFT) begin
            r_work <= w_shifted;
            r_cnt  <= r_cnt - CNT_ONE;
        end else begin
            r_work <= r_work;
            r_cnt  <= r_cnt;
        end
    end

    assign o_busy  = (r_state == ST_SHIFT);
    assign o_done  = w_done;
    assign o_value = w_shifted;
    assign o_rd    = r_rd;

endmodule

// File: rtl/exec_alu_stage.sv
// Execute stage: single-cycle ALU, optional iterative shifter, registered result with valid/ready.
module exec_alu_stage
    import exec_alu_stage_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter bit FAST_SHIFT = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    localparam int SHW = $clog2(XLEN);

    logic            r_valid;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_rd;
    logic            r_illegal;

    logic [SHW-1:0]  w_shamt;
    logic            w_accept;
    logic            w_start_iter;
    logic [XLEN-1:0] w_alu_result;
    logic            w_alu_illegal;
    logic            w_sh_busy;
    logic            w_sh_done;
    logic [XLEN-1:0] w_sh_value;
    logic [4:0]      w_sh_rd;

    assign w_shamt      = in_rs2[SHW-1:0];
    assign in_ready     = rst_n && !w_sh_busy && (!r_valid || out_ready);
    assign w_accept     = in_valid && in_ready;
    assign w_start_iter = w_accept && !FAST_SHIFT && is_shift_op(in_op)
                          && (w_shamt != {SHW{1'b0}});

    // Combinational ALU; slow-shift builds only ever see amount 0 here.
    always_comb begin
        w_alu_result  = {XLEN{1'b0}};
        w_alu_illegal = 1'b0;
        case (in_op)
            OP_ADD:  w_alu_result = in_rs1 + in_rs2;
            OP_SUB:  w_alu_result = in_rs1 - in_rs2;
            OP_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(in_rs1) < $signed(in_rs2))};
            OP_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, (in_rs1 < in_rs2)};
            OP_XOR:  w_alu_result = in_rs1 ^ in_rs2;
            OP_OR:   w_alu_result = in_rs1 | in_rs2;
            OP_AND:  w_alu_result = in_rs1 & in_rs2;
            OP_SLL: begin
                if (FAST_SHIFT) w_alu_result = in_rs1 << w_shamt;
                else            w_alu_result = in_rs1;
            end
            OP_SRL: begin
                if (FAST_SHIFT) w_alu_result = in_rs1 >> w_shamt;
                else            w_alu_result = in_rs1;
            end
            OP_SRA: begin
                if (FAST_SHIFT) w_alu_result = $unsigned($signed(in_rs1) >>> w_shamt);
                else            w_alu_result = in_rs1;
            end
            default: w_alu_illegal = 1'b1;
        endcase
    end

    exec_alu_stage_iter_shifter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_iter_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start_iter),
        .i_op     (in_op),
        .i_value  (in_rs1),
        .i_amount (w_shamt),
        .i_rd     (in_rd),
        .o_busy   (w_sh_busy),
        .o_done   (w_sh_done),
        .o_value  (w_sh_value),
        .o_rd     (w_sh_rd)
    );

    // Output register: load on a single-cycle accept or shifter completion, clear on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_result  <= {XLEN{1'b0}};
            r_rd      <= 5'd0;
            r_illegal <= 1'b0;
        end else if (w_accept && !w_start_iter) begin
            r_valid   <= 1'b1;
            r_result  <= w_alu_result;
            r_rd      <= in_rd;
            r_illegal <= w_alu_illegal;
        end else if (w_sh_done) begin
            r_valid   <= 1'b1;
            r_result  <= w_sh_value;
            r_rd      <= w_sh_rd;
            r_illegal <= 1'b0;
        end else if (out_ready) begin
            r_valid   <= 1'b0;
        end else begin
            r_valid   <= r_valid;
        end
    end

    assign out_valid   = r_valid;
    assign out_result  = r_result;
    assign out_rd      = r_rd;
    assign out_illegal = r_illegal;

endmodule

// File: tb/tb_exec_alu_stage.sv
// Directed testbench for exec_alu_stage: iterative-shift instance plus a fast-shift instance.
module tb_exec_alu_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_rd;
    logic        out_ready;

    logic        s_in_ready,  s_out_valid,  s_out_illegal;
    logic [31:0] s_out_result;
    logic [4:0]  s_out_rd;
    logic        f_in_ready,  f_out_valid,  f_out_illegal;
    logic [31:0] f_out_result;
    logic [4:0]  f_out_rd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exec_alu_stage #(.XLEN(32), .FAST_SHIFT(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_result(s_out_result),
        .out_rd(s_out_rd), .out_illegal(s_out_illegal)
    );

    exec_alu_stage #(.XLEN(32), .FAST_SHIFT(1'b1)) u_dut_fast (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(f_in_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .out_valid(f_out_valid), .out_ready(out_ready), .out_result(f_out_result),
        .out_rd(f_out_rd), .out_illegal(f_out_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Present one op for exactly one accepting edge, then land on the next negedge.
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
    endtask

    // Single-cycle op on the iterative instance, checked one cycle after accept.
    task automatic op1(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input logic exp_ill);
        drive(op, a, b, rd);
        chk({tag, "_valid"}, {31'd0, s_out_valid}, 32'd1);
        chk({tag, "_result"}, s_out_result, exp);
        chk({tag, "_rd"}, {27'd0, s_out_rd}, {27'd0, rd});
        chk({tag, "_illegal"}, {31'd0, s_out_illegal}, {31'd0, exp_ill});
    endtask

    initial begin
        int  cyc;
        logic flag;
        rst_n = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_rs1 = 32'd0; in_rs2 = 32'd0;
        in_rd = 5'd0; out_ready = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_valid",   {31'd0, s_out_valid}, 32'd0);
        chk("rst_result",  s_out_result, 32'd0);
        chk("rst_rd",      {27'd0, s_out_rd}, 32'd0);
        chk("rst_illegal", {31'd0, s_out_illegal}, 32'd0);
        chk("rst_ready",   {31'd0, s_in_ready}, 32'd0);
        rst_n = 1'b1;
        #1 chk("post_rst_ready", {31'd0, s_in_ready}, 32'd1);

        // Arithmetic and logic.
        op1("add",  4'b0001, 32'hFFFF_FFFF, 32'h0000_0001, 5'd5,  32'h0000_0000, 1'b0);
        op1("sub",  4'b0010, 32'h0000_0000, 32'h0000_0001, 5'd6,  32'hFFFF_FFFF, 1'b0);
        op1("slt",  4'b0100, 32'hFFFF_FFFF, 32'h0000_0001, 5'd7,  32'h0000_0001, 1'b0);
        op1("sltu", 4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 5'd8,  32'h0000_0000, 1'b0);
        op1("or",   4'b1001, 32'h1200_0034, 32'h0056_7800, 5'd9,  32'h1256_7834, 1'b0);
        op1("and",  4'b1010, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd10, 32'h0F00_0F00, 1'b0);
        op1("sll0", 4'b0011, 32'h0000_0001, 32'h0000_0000, 5'd11, 32'h0000_0001, 1'b0);

        // Illegal codes: no stall, result 0, following ADD clean.
        op1("ill0", 4'b0000, 32'h1234_5678, 32'h1111_1111, 5'd12, 32'h0000_0000, 1'b1);
        chk("ill0_ready", {31'd0, s_in_ready}, 32'd1);
        op1("ill15", 4'b1111, 32'h1234_5678, 32'h1111_1111, 5'd13, 32'h0000_0000, 1'b1);
        op1("add_after_ill", 4'b0001, 32'h0000_0002, 32'h0000_0003, 5'd14, 32'h0000_0005, 1'b0);

        // SRA by 31 (upper rs2 bits ignored) on the iterative shifter: 32-cycle latency.
        drive(4'b1000, 32'h8000_0000, 32'h0000_003F, 5'd15);
        cyc = 1; flag = 1'b1;
        while (!s_out_valid && cyc < 100) begin
            if (s_in_ready !== 1'b0) flag = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk("sra_latency", cyc, 32'd32);
        chk("sra_busy_ready", {31'd0, flag}, 32'd1);
        chk("sra_result", s_out_result, 32'hFFFF_FFFF);
        chk("sra_rd", {27'd0, s_out_rd}, 32'd15);
        @(negedge clk);

        // SRL by 4: fast instance latency 1, iterative instance latency 5.
        drive(4'b0111, 32'h8000_0000, 32'h0000_0004, 5'd16);
        chk("fast_srl_valid",  {31'd0, f_out_valid}, 32'd1);
        chk("fast_srl_result", f_out_result, 32'h0800_0000);
        chk("fast_srl_ill",    {31'd0, f_out_illegal}, 32'd0);
        cyc = 1;
        while (!s_out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("slow_srl_latency", cyc, 32'd5);
        chk("slow_srl_result", s_out_result, 32'h0800_0000);
        @(negedge clk);

        // Backpressure: result held for 5 cycles, consumed on first out_ready.
        out_ready = 1'b0;
        drive(4'b0110, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'd17);
        flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (s_out_valid !== 1'b1 || s_out_result !== 32'hFFFF_FFFF || s_in_ready !== 1'b0)
                flag = 1'b0;
            @(negedge clk);
        end
        chk("bp_hold", {31'd0, flag}, 32'd1);
        chk("bp_result", s_out_result, 32'hFFFF_FFFF);
        out_ready = 1'b1;
        #1 chk("bp_ready_release", {31'd0, s_in_ready}, 32'd1);
        @(negedge clk);
        chk("bp_consumed", {31'd0, s_out_valid}, 32'd0);

        // Reset mid-shift: outputs zero at once, no result afterwards.
        drive(4'b0011, 32'h0000_0001, 32'h0000_000A, 5'd18);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",  {31'd0, s_out_valid}, 32'd0);
        chk("mid_rst_result", s_out_result, 32'd0);
        chk("mid_rst_ready",  {31'd0, s_in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (s_out_valid !== 1'b0) flag = 1'b0;
        end
        chk("mid_rst_no_result", {31'd0, flag}, 32'd1);
        chk("mid_rst_ready_back", {31'd0, s_in_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_alu_stage.md
Name: exec_alu_stage

Overview:
- Execute stage directly downstream of the R-type operation decoder; consumes its 4-bit operation code plus the two source operands.
- Produces a registered result with a valid/ready handshake toward writeback.
- Logic ops and add/sub complete in 1 cycle.
- Shifts run on an iterative 1-bit-per-cycle shifter FSM (area-saving); FAST_SHIFT selects a single-cycle barrel shifter instead.

Parameters:
- XLEN, 32, operand/result width; must be a power of 2, at least 8.
- FAST_SHIFT, 0, 1 = shifts complete in 1 cycle like other ops; 0 = iterative shifter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream has an operation
- in_ready  out  1  stage can accept this cycle
- in_op  in  4  operation code: 0001 ADD, 0010 SUB, 0011 SLL, 0100 SLT, 0101 SLTU, 0110 XOR, 0111 SRL, 1000 SRA, 1001 OR, 1010 AND; all other values are illegal
- in_rs1  in  XLEN  operand A
- in_rs2  in  XLEN  operand B; shift amount = in_rs2[log2(XLEN)-1:0]
- in_rd  in  5  destination register tag, passed through
- out_valid  out  1  result register holds a result
- out_ready  in  1  downstream consumes the result
- out_result  out  XLEN  result
- out_rd  out  5  tag of the result
- out_illegal  out  1  the op code was illegal

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - FSM goes to IDLE.
  - out_valid=0, out_result=0, out_rd=0, out_illegal=0, in_ready=0 while rst_n low.
  - Internal shift register and counter are cleared.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
  - While out_valid && !out_ready, out_* hold stable.
  - out_valid clears on out_ready unless a new result is written in the same cycle.
- FSM states: IDLE, SHIFT.
  - IDLE, accept of a non-shift op, legal or illegal, or a shift with amount 0, or any shift when FAST_SHIFT=1:
    - Result is written to the output register at the next edge; latency 1.
    - out_valid=1.
  - IDLE, accept of SLL/SRL/SRA with amount N>0 and FAST_SHIFT=0:
    - Latch rs1 into the work register, N into the counter, op and rd into holding registers.
    - Go to SHIFT.
  - SHIFT, each cycle:
    - Work register shifts by 1: SLL inserts 0 at LSB, SRL inserts 0 at MSB, SRA replicates the MSB.
    - Counter decrements.
    - When the counter goes from 1 to 0, the shifted value is written to the output, out_valid=1, and the FSM returns to IDLE.
    - Accept-to-out_valid latency is N+1 cycles.
    - out_valid is 0 throughout SHIFT. The output register is guaranteed empty because in_ready required it at accept.
- Arithmetic:
  - ADD/SUB are modulo 2^XLEN; no overflow flag.
  - SLT is a signed compare, SLTU an unsigned compare; the result is 0 or 1, zero-extended.
  - Shift amount uses only the low log2(XLEN) bits of rs2; upper bits are ignored.
- Illegal op: out_result=0, out_illegal=1, out_rd=in_rd, latency 1. The block does not stall.
- out_illegal=0 for every legal op.
- Reset mid-SHIFT: the operation is aborted and no result is emitted.
- Back-to-back: one op per cycle sustained for non-shift ops when out_ready=1.

Decomposition:
- Shared package holds:
  - The op-code constants (OP_ADD … OP_AND, OP_ILLEGAL=0000), shared with the decoder.
  - The FSM state encoding.
  - The XLEN default.
- One natural sub-module, `iter_shifter`: work register, counter, done pulse.
- The top holds the ALU combinational logic, the output register and the handshake.

Test Plan:
- ADD 0xFFFFFFFF + 0x00000001, rd=5 -> out_result 0x00000000, out_rd 5, out_valid one cycle after accept.
- SUB 0x00000000 - 0x00000001 -> 0xFFFFFFFF. SLT 0xFFFFFFFF vs 0x00000001 -> 1. SLTU on the same operands -> 0.
- SRA 0x80000000 by rs2=0x0000003F (amount 31), FAST_SHIFT=0 -> 0xFFFFFFFF after 32 cycles; in_ready=0 throughout.
- SLL 0x00000001 by 0 -> 0x00000001 at latency 1. Repeat with FAST_SHIFT=1, SRL 0x80000000 by 4 -> 0x08000000 at latency 1.
- in_op=0000 and in_op=1111 -> out_illegal=1, out_result=0, no stall; the following ADD gives out_illegal=0.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles after an XOR 0xF0F0F0F0^0x0F0F0F0F -> out_result stays 0xFFFFFFFF and in_ready=0; the result is consumed on the first out_ready=1.
  - Assert rst_n=0 mid-SHIFT -> all outputs 0 immediately; no result after release.
